// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// req/gnt is a standard valid/ready handshake; rvalid follows for every granted access.
interface lsu_ctrl_if;
  logic        data_req_op;
  logic        data_gnt_ip;
  logic [31:0] data_addr_op;
  logic        data_we_op;
  logic [3:0]  data_be_op;
  logic [31:0] data_wdata_op;
  logic        data_rvalid_ip;
  logic [31:0] data_rdata_ip;

  modport master (
    output data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
    input  data_gnt_ip, data_rvalid_ip, data_rdata_ip
  );

  modport slave (
    input  data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
    output data_gnt_ip, data_rvalid_ip, data_rdata_ip
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts an ALU address, runs req/gnt/rvalid to data
// memory and returns aligned, extended load data with a one-cycle completion pulse.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_enable_ip,
  input  logic        lsu_we_ip,
  input  logic [1:0]  lsu_size_ip,
  input  logic        lsu_sign_ext_ip,
  input  logic [31:0] lsu_wdata_ip,
  input  logic [31:0] alu_result_ip,
  input  logic        alu_valid_ip,
  lsu_ctrl_if.master  mem,
  output logic [31:0] lsu_rdata_op,
  output logic        lsu_valid_op,
  output logic [1:0]  lsu_err_op,
  output logic        lsu_busy_op,
  output logic [1:0]  dbg_state_op
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
  localparam logic [15:0] CNT_LAST     = 16'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic [1:0]  err_q, err_d;

  logic        misaligned;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Size 2'b11 falls through to the word cases everywhere below.
  always_comb begin
    misaligned = 1'b0;
    case (lsu_size_ip)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_ip[0];
      default: misaligned = (alu_result_ip[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    lane     = mem.data_rdata_ip >> {off_q, 3'b000};
    load_ext = lane;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{sign_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    off_d   = off_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (lsu_enable_ip && alu_valid_ip) begin
          if (misaligned) begin
            valid_d = 1'b1;
            err_d   = ERR_MISALIGN;
            rdata_d = 32'h0;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = {alu_result_ip[31:2], 2'b00};
            off_d   = alu_result_ip[1:0];
            we_d    = lsu_we_ip;
            size_d  = lsu_size_ip;
            sign_d  = lsu_sign_ext_ip;
            case (lsu_size_ip)
              2'b00: begin
                be_d    = 4'b0001 << alu_result_ip[1:0];
                wdata_d = {4{lsu_wdata_ip[7:0]}};
              end
              2'b01: begin
                be_d    = 4'b0011 << alu_result_ip[1:0];
                wdata_d = {2{lsu_wdata_ip[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_wdata_ip;
              end
            endcase
          end
        end
      end
      REQ: begin
        // rvalid is deliberately not looked at here, even alongside gnt.
        if (mem.data_gnt_ip) begin
          state_d = WAIT_RVALID;
          req_d   = 1'b0;
          cnt_d   = 16'h0;
        end
      end
      WAIT_RVALID: begin
        if (mem.data_rvalid_ip) begin
          state_d = IDLE;
          valid_d = 1'b1;
          rdata_d = we_q ? 32'h0 : load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          valid_d = 1'b1;
          err_d   = ERR_TIMEOUT;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      cnt_q   <= 16'h0;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign mem.data_req_op   = req_q;
  assign mem.data_addr_op  = addr_q;
  assign mem.data_we_op    = we_q;
  assign mem.data_be_op    = be_q;
  assign mem.data_wdata_op = wdata_q;
  assign lsu_rdata_op      = rdata_q;
  assign lsu_valid_op      = valid_q;
  assign lsu_err_op        = err_q;
  assign lsu_busy_op       = (state_q != IDLE);
  assign dbg_state_op      = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: each task drives one scenario against hand-computed values.
module tb_lsu_ctrl;
  logic        clk;
  logic        reset;
  logic        lsu_enable_ip;
  logic        lsu_we_ip;
  logic [1:0]  lsu_size_ip;
  logic        lsu_sign_ext_ip;
  logic [31:0] lsu_wdata_ip;
  logic [31:0] alu_result_ip;
  logic        alu_valid_ip;
  logic [31:0] lsu_rdata_op;
  logic        lsu_valid_op;
  logic [1:0]  lsu_err_op;
  logic        lsu_busy_op;
  logic [1:0]  dbg_state_op;

  int n_cmp;
  int n_err;

  lsu_ctrl_if mem_if ();

  lsu_ctrl #(.MAX_WAIT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .lsu_enable_ip   (lsu_enable_ip),
    .lsu_we_ip       (lsu_we_ip),
    .lsu_size_ip     (lsu_size_ip),
    .lsu_sign_ext_ip (lsu_sign_ext_ip),
    .lsu_wdata_ip    (lsu_wdata_ip),
    .alu_result_ip   (alu_result_ip),
    .alu_valid_ip    (alu_valid_ip),
    .mem             (mem_if),
    .lsu_rdata_op    (lsu_rdata_op),
    .lsu_valid_op    (lsu_valid_op),
    .lsu_err_op      (lsu_err_op),
    .lsu_busy_op     (lsu_busy_op),
    .dbg_state_op    (dbg_state_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] wdata, input logic [31:0] addr);
    lsu_enable_ip   = 1'b1;
    alu_valid_ip    = 1'b1;
    lsu_we_ip       = we;
    lsu_size_ip     = size;
    lsu_sign_ext_ip = sign;
    lsu_wdata_ip    = wdata;
    alu_result_ip   = addr;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] wdata, input logic [31:0] addr);
    drive_op(we, size, sign, wdata, addr);
    step();
    lsu_enable_ip = 1'b0;
    alu_valid_ip  = 1'b0;
  endtask

  task automatic grant_then_rvalid(input logic [31:0] rdata);
    mem_if.data_gnt_ip = 1'b1;
    step();
    mem_if.data_gnt_ip    = 1'b0;
    mem_if.data_rvalid_ip = 1'b1;
    mem_if.data_rdata_ip  = rdata;
    step();
    mem_if.data_rvalid_ip = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++; if (mem_if.data_req_op !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", mem_if.data_req_op); end
    n_cmp++; if (mem_if.data_we_op !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0b want 0", mem_if.data_we_op); end
    n_cmp++; if (mem_if.data_be_op !== 4'h0) begin n_err++; $display("FAIL rst_be: got %h want 0", mem_if.data_be_op); end
    n_cmp++; if (mem_if.data_addr_op !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_if.data_addr_op); end
    n_cmp++; if (mem_if.data_wdata_op !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", mem_if.data_wdata_op); end
    n_cmp++; if (lsu_rdata_op !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", lsu_rdata_op); end
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (lsu_err_op !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b want 00", lsu_err_op); end
    n_cmp++; if (lsu_busy_op !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", lsu_busy_op); end
    n_cmp++; if (dbg_state_op !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state_op); end
  endtask

  task automatic test_word_load();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0100);
    n_cmp++; if (mem_if.data_req_op !== 1'b1) begin n_err++; $display("FAIL wl_req: got %0b want 1", mem_if.data_req_op); end
    n_cmp++; if (mem_if.data_addr_op !== 32'h0000_0100) begin n_err++; $display("FAIL wl_addr: got %h want 00000100", mem_if.data_addr_op); end
    n_cmp++; if (mem_if.data_be_op !== 4'b1111) begin n_err++; $display("FAIL wl_be: got %b want 1111", mem_if.data_be_op); end
    n_cmp++; if (mem_if.data_we_op !== 1'b0) begin n_err++; $display("FAIL wl_we: got %0b want 0", mem_if.data_we_op); end
    n_cmp++; if (lsu_busy_op !== 1'b1) begin n_err++; $display("FAIL wl_busy: got %0b want 1", lsu_busy_op); end
    step();
    step();
    n_cmp++; if (mem_if.data_req_op !== 1'b1) begin n_err++; $display("FAIL wl_req_held: got %0b want 1", mem_if.data_req_op); end
    n_cmp++; if (mem_if.data_addr_op !== 32'h0000_0100) begin n_err++; $display("FAIL wl_addr_held: got %h want 00000100", mem_if.data_addr_op); end
    mem_if.data_gnt_ip = 1'b1;
    step();
    mem_if.data_gnt_ip = 1'b0;
    n_cmp++; if (mem_if.data_req_op !== 1'b0) begin n_err++; $display("FAIL wl_req_drop: got %0b want 0", mem_if.data_req_op); end
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL wl_early_valid: got %0b want 0", lsu_valid_op); end
    mem_if.data_rvalid_ip = 1'b1;
    mem_if.data_rdata_ip  = 32'hDEAD_BEEF;
    step();
    mem_if.data_rvalid_ip = 1'b0;
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL wl_valid: got %0b want 1", lsu_valid_op); end
    n_cmp++; if (lsu_rdata_op !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wl_rdata: got %h want deadbeef", lsu_rdata_op); end
    n_cmp++; if (lsu_err_op !== 2'b00) begin n_err++; $display("FAIL wl_err: got %b want 00", lsu_err_op); end
    n_cmp++; if (lsu_busy_op !== 1'b0) begin n_err++; $display("FAIL wl_busy_done: got %0b want 0", lsu_busy_op); end
    step();
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL wl_pulse: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (lsu_rdata_op !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wl_rdata_hold: got %h want deadbeef", lsu_rdata_op); end
  endtask

  task automatic test_byte_load();
    issue(1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0203);
    n_cmp++; if (mem_if.data_be_op !== 4'b1000) begin n_err++; $display("FAIL bl_be: got %b want 1000", mem_if.data_be_op); end
    n_cmp++; if (mem_if.data_addr_op !== 32'h0000_0200) begin n_err++; $display("FAIL bl_addr: got %h want 00000200", mem_if.data_addr_op); end
    grant_then_rvalid(32'h8012_3456);
    n_cmp++; if (lsu_rdata_op !== 32'hFFFF_FF80) begin n_err++; $display("FAIL bl_sext: got %h want ffffff80", lsu_rdata_op); end
    step();
    issue(1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0203);
    grant_then_rvalid(32'h8012_3456);
    n_cmp++; if (lsu_rdata_op !== 32'h0000_0080) begin n_err++; $display("FAIL bl_zext: got %h want 00000080", lsu_rdata_op); end
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL bl_valid: got %0b want 1", lsu_valid_op); end
    step();
  endtask

  task automatic test_half_store();
    issue(1'b1, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0000_0032);
    n_cmp++; if (mem_if.data_be_op !== 4'b1100) begin n_err++; $display("FAIL hs_be: got %b want 1100", mem_if.data_be_op); end
    n_cmp++; if (mem_if.data_wdata_op !== 32'hABCD_ABCD) begin n_err++; $display("FAIL hs_wdata: got %h want abcdabcd", mem_if.data_wdata_op); end
    n_cmp++; if (mem_if.data_we_op !== 1'b1) begin n_err++; $display("FAIL hs_we: got %0b want 1", mem_if.data_we_op); end
    n_cmp++; if (mem_if.data_addr_op !== 32'h0000_0030) begin n_err++; $display("FAIL hs_addr: got %h want 00000030", mem_if.data_addr_op); end
    grant_then_rvalid(32'h1234_5678);
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL hs_valid: got %0b want 1", lsu_valid_op); end
    n_cmp++; if (lsu_rdata_op !== 32'h0) begin n_err++; $display("FAIL hs_rdata: got %h want 0", lsu_rdata_op); end
    step();
    issue(1'b1, 2'b00, 1'b0, 32'h0000_005A, 32'h0000_0041);
    n_cmp++; if (mem_if.data_wdata_op !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL bs_wdata: got %h want 5a5a5a5a", mem_if.data_wdata_op); end
    n_cmp++; if (mem_if.data_be_op !== 4'b0010) begin n_err++; $display("FAIL bs_be: got %b want 0010", mem_if.data_be_op); end
    grant_then_rvalid(32'h0);
    step();
  endtask

  task automatic test_misaligned();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0102);
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL ma_valid: got %0b want 1", lsu_valid_op); end
    n_cmp++; if (lsu_err_op !== 2'b01) begin n_err++; $display("FAIL ma_err: got %b want 01", lsu_err_op); end
    n_cmp++; if (lsu_rdata_op !== 32'h0) begin n_err++; $display("FAIL ma_rdata: got %h want 0", lsu_rdata_op); end
    n_cmp++; if (mem_if.data_req_op !== 1'b0) begin n_err++; $display("FAIL ma_req: got %0b want 0", mem_if.data_req_op); end
    n_cmp++; if (lsu_busy_op !== 1'b0) begin n_err++; $display("FAIL ma_busy: got %0b want 0", lsu_busy_op); end
    step();
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL ma_pulse: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (mem_if.data_req_op !== 1'b0) begin n_err++; $display("FAIL ma_req_after: got %0b want 0", mem_if.data_req_op); end
    issue(1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0011);
    n_cmp++; if (lsu_err_op !== 2'b01) begin n_err++; $display("FAIL ma_half_err: got %b want 01", lsu_err_op); end
    step();
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0000_0020);
    n_cmp++; if (mem_if.data_be_op !== 4'b1111) begin n_err++; $display("FAIL sz11_be: got %b want 1111", mem_if.data_be_op); end
    grant_then_rvalid(32'hCAFE_F00D);
    n_cmp++; if (lsu_rdata_op !== 32'hCAFE_F00D) begin n_err++; $display("FAIL sz11_rdata: got %h want cafef00d", lsu_rdata_op); end
    step();
  endtask

  task automatic test_timeout();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0040);
    mem_if.data_gnt_ip = 1'b1;
    step();
    mem_if.data_gnt_ip = 1'b0;
    step();
    step();
    step();
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL to_early: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (lsu_busy_op !== 1'b1) begin n_err++; $display("FAIL to_busy: got %0b want 1", lsu_busy_op); end
    step();
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL to_valid: got %0b want 1", lsu_valid_op); end
    n_cmp++; if (lsu_err_op !== 2'b10) begin n_err++; $display("FAIL to_err: got %b want 10", lsu_err_op); end
    n_cmp++; if (lsu_rdata_op !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h want 0", lsu_rdata_op); end
    n_cmp++; if (lsu_busy_op !== 1'b0) begin n_err++; $display("FAIL to_idle: got %0b want 0", lsu_busy_op); end
    mem_if.data_rvalid_ip = 1'b1;
    mem_if.data_rdata_ip  = 32'h5555_5555;
    step();
    mem_if.data_rvalid_ip = 1'b0;
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL to_late: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (lsu_err_op !== 2'b00) begin n_err++; $display("FAIL to_err_pulse: got %b want 00", lsu_err_op); end
    // rvalid on the final allowed wait cycle beats the timeout
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0044);
    mem_if.data_gnt_ip = 1'b1;
    step();
    mem_if.data_gnt_ip = 1'b0;
    step();
    step();
    step();
    mem_if.data_rvalid_ip = 1'b1;
    mem_if.data_rdata_ip  = 32'h0BAD_CAFE;
    step();
    mem_if.data_rvalid_ip = 1'b0;
    n_cmp++; if (lsu_err_op !== 2'b00) begin n_err++; $display("FAIL to_edge_err: got %b want 00", lsu_err_op); end
    n_cmp++; if (lsu_rdata_op !== 32'h0BAD_CAFE) begin n_err++; $display("FAIL to_edge_rdata: got %h want 0badcafe", lsu_rdata_op); end
    step();
  endtask

  task automatic test_rvalid_in_req();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0080);
    mem_if.data_gnt_ip    = 1'b1;
    mem_if.data_rvalid_ip = 1'b1;
    mem_if.data_rdata_ip  = 32'h1111_1111;
    step();
    mem_if.data_gnt_ip    = 1'b0;
    mem_if.data_rvalid_ip = 1'b0;
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL rq_rv_valid: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (lsu_busy_op !== 1'b1) begin n_err++; $display("FAIL rq_rv_busy: got %0b want 1", lsu_busy_op); end
    mem_if.data_rvalid_ip = 1'b1;
    mem_if.data_rdata_ip  = 32'h2222_2222;
    step();
    mem_if.data_rvalid_ip = 1'b0;
    n_cmp++; if (lsu_rdata_op !== 32'h2222_2222) begin n_err++; $display("FAIL rq_rv_rdata: got %h want 22222222", lsu_rdata_op); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0080);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (mem_if.data_req_op !== 1'b0) begin n_err++; $display("FAIL rm_req: got %0b want 0", mem_if.data_req_op); end
    n_cmp++; if (lsu_busy_op !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %0b want 0", lsu_busy_op); end
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %0b want 0", lsu_valid_op); end
    mem_if.data_rvalid_ip = 1'b1;
    step();
    mem_if.data_rvalid_ip = 1'b0;
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL rm_late: got %0b want 0", lsu_valid_op); end
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0000);
    n_cmp++; if (mem_if.data_addr_op !== 32'h0) begin n_err++; $display("FAIL rm_addr0: got %h want 0", mem_if.data_addr_op); end
    grant_then_rvalid(32'h1122_3344);
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL rm_next_valid: got %0b want 1", lsu_valid_op); end
    n_cmp++; if (lsu_rdata_op !== 32'h1122_3344) begin n_err++; $display("FAIL rm_next_rdata: got %h want 11223344", lsu_rdata_op); end
    step();
  endtask

  task automatic test_no_alu_valid();
    lsu_enable_ip = 1'b1;
    alu_valid_ip  = 1'b0;
    alu_result_ip = 32'h0000_0100;
    step();
    step();
    lsu_enable_ip = 1'b0;
    n_cmp++; if (mem_if.data_req_op !== 1'b0) begin n_err++; $display("FAIL nv_req: got %0b want 0", mem_if.data_req_op); end
    n_cmp++; if (lsu_busy_op !== 1'b0) begin n_err++; $display("FAIL nv_busy: got %0b want 0", lsu_busy_op); end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0010);
    grant_then_rvalid(32'hA5A5_A5A5);
    n_cmp++; if (lsu_valid_op !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %0b want 1", lsu_valid_op); end
    issue(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0006);
    n_cmp++; if (mem_if.data_req_op !== 1'b1) begin n_err++; $display("FAIL b2b_req: got %0b want 1", mem_if.data_req_op); end
    n_cmp++; if (lsu_valid_op !== 1'b0) begin n_err++; $display("FAIL b2b_pulse: got %0b want 0", lsu_valid_op); end
    n_cmp++; if (mem_if.data_be_op !== 4'b1100) begin n_err++; $display("FAIL b2b_be: got %b want 1100", mem_if.data_be_op); end
    n_cmp++; if (mem_if.data_addr_op !== 32'h0000_0004) begin n_err++; $display("FAIL b2b_addr: got %h want 00000004", mem_if.data_addr_op); end
    grant_then_rvalid(32'h8001_0000);
    n_cmp++; if (lsu_rdata_op !== 32'hFFFF_8001) begin n_err++; $display("FAIL b2b_rdata: got %h want ffff8001", lsu_rdata_op); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset                 = 1'b1;
    lsu_enable_ip         = 1'b0;
    lsu_we_ip             = 1'b0;
    lsu_size_ip           = 2'b00;
    lsu_sign_ext_ip       = 1'b0;
    lsu_wdata_ip          = 32'h0;
    alu_result_ip         = 32'h0;
    alu_valid_ip          = 1'b0;
    mem_if.data_gnt_ip    = 1'b0;
    mem_if.data_rvalid_ip = 1'b0;
    mem_if.data_rdata_ip  = 32'h0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_rvalid_in_req();
    test_reset_mid();
    test_no_alu_valid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
